// File: rtl/sram_1rw1r_wmask_clr_if.sv
// Bus bundle for sram_1rw1r_wmask_clr: port 0 (read/write), port 1 (read-only)
// and the clear-sequencer status strobes.
interface sram_1rw1r_wmask_clr_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WMASKS = 4
);
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  busy;
  logic                  reject;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout0_valid, dout1, dout1_valid, busy, reject, collision
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout0_valid, dout1, dout1_valid, busy, reject, collision
  );
endinterface

// File: rtl/sram_1rw1r_wmask_clr.sv
// 1RW + 1R single-clock SRAM with lane write mask, registered reads, same-address
// write-to-read forwarding and a post-reset memory clear sweep.
module sram_1rw1r_wmask_clr #(
  parameter int unsigned DATA_WIDTH               = 32,
  parameter int unsigned ADDR_WIDTH               = 8,
  parameter int unsigned WMASK_LANE               = 8,
  parameter int unsigned NUM_WMASKS               = DATA_WIDTH / WMASK_LANE,
  parameter bit          BYPASS                   = 1'b1,
  parameter bit          CLEAR_ON_RESET           = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic clk0,
  input logic rst0,
  sram_1rw1r_wmask_clr_if.slave bus
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % WMASK_LANE) != 0 || NUM_WMASKS != DATA_WIDTH / WMASK_LANE) begin : g_bad_lane
    $error("DATA_WIDTH must be an exact multiple of WMASK_LANE");
  end

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  dout0_valid_q, dout0_valid_d;
  logic                  dout1_valid_q, dout1_valid_d;
  logic                  reject_q, reject_d;
  logic                  collision_q, collision_d;

  logic                  busy;
  logic                  rd0, wr0, rd1;
  logic [NUM_WMASKS-1:0] lane_we;
  logic [DATA_WIDTH-1:0] old0;
  logic [DATA_WIDTH-1:0] merged0;

  assign busy = (state_q == ST_CLEAR);
  assign rd0  = !busy && !bus.csb0 &&  bus.web0;
  assign wr0  = !busy && !bus.csb0 && !bus.web0;
  assign rd1  = !busy && !bus.csb1;
  assign old0 = mem[bus.addr0];

  // merged0 is the word port 0 leaves behind; also the bypass value for port 1
  always_comb begin
    merged0 = old0;
    lane_we = '0;
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      lane_we[i] = wr0 && bus.wmask0[i];
      if (bus.wmask0[i]) begin
        merged0[i*WMASK_LANE +: WMASK_LANE] = bus.din0[i*WMASK_LANE +: WMASK_LANE];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == ST_CLEAR) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    dout0_d       = dout0_q;
    dout1_d       = dout1_q;
    dout0_valid_d = rd0;
    dout1_valid_d = rd1;
    reject_d      = busy && (!bus.csb0 || !bus.csb1);
    collision_d   = wr0 && rd1 && (bus.addr0 == bus.addr1) && (|bus.wmask0);
    if (rd0) begin
      dout0_d = old0;
    end
    if (rd1) begin
      dout1_d = (collision_d && BYPASS) ? merged0 : mem[bus.addr1];
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q       <= RST_STATE;
      cnt_q         <= '0;
      dout0_q       <= '0;
      dout1_q       <= '0;
      dout0_valid_q <= 1'b0;
      dout1_valid_q <= 1'b0;
      reject_q      <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dout0_q       <= dout0_d;
      dout1_q       <= dout1_d;
      dout0_valid_q <= dout0_valid_d;
      dout1_valid_q <= dout1_valid_d;
      reject_q      <= reject_d;
      collision_q   <= collision_d;
    end
  end

  // Array has no reset; the sweep and port 0 are mutually exclusive via busy
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (clr_we) begin
        mem[cnt_q] <= CLEAR_VALUE;
      end else begin
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
          if (lane_we[i]) begin
            mem[bus.addr0][i*WMASK_LANE +: WMASK_LANE] <= bus.din0[i*WMASK_LANE +: WMASK_LANE];
          end
        end
      end
    end
  end

  assign bus.dout0       = dout0_q;
  assign bus.dout1       = dout1_q;
  assign bus.dout0_valid = dout0_valid_q;
  assign bus.dout1_valid = dout1_valid_q;
  assign bus.busy        = busy;
  assign bus.reject      = reject_q;
  assign bus.collision   = collision_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask_clr.sv
// Randomised self-checking bench: a BYPASS=1 and a BYPASS=0 instance share the
// same stimulus and are compared every cycle against an array-based reference.
module tb_sram_1rw1r_wmask_clr;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NM    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [DW-1:0] CV  = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_1rw1r_wmask_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bi ();
  sram_1rw1r_wmask_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bo ();

  assign bo.csb0   = bi.csb0;
  assign bo.web0   = bi.web0;
  assign bo.wmask0 = bi.wmask0;
  assign bo.addr0  = bi.addr0;
  assign bo.din0   = bi.din0;
  assign bo.csb1   = bi.csb1;
  assign bo.addr1  = bi.addr1;

  sram_1rw1r_wmask_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_LANE(8),
    .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) u_dut_byp (
    .clk0(clk), .rst0(rst), .bus(bi)
  );

  sram_1rw1r_wmask_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_LANE(8),
    .BYPASS(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) u_dut_nobyp (
    .clk0(clk), .rst0(rst), .bus(bo)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            left = 0;
  logic [DW-1:0] e_d0 = '0, e_d1b = '0, e_d1n = '0;
  logic          e_v0 = 1'b0, e_v1 = 1'b0, e_rej = 1'b0, e_col = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input logic r, input logic c0, input logic w0, input logic [NM-1:0] m,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic c1, input logic [AW-1:0] a1);
    rst = r; bi.csb0 = c0; bi.web0 = w0; bi.wmask0 = m;
    bi.addr0 = a0; bi.din0 = d0; bi.csb1 = c1; bi.addr1 = a1;
    if (r) begin
      e_d0 = '0; e_d1b = '0; e_d1n = '0;
      e_v0 = 1'b0; e_v1 = 1'b0; e_rej = 1'b0; e_col = 1'b0;
      left = DEPTH;
    end else if (left > 0) begin
      e_v0 = 1'b0; e_v1 = 1'b0; e_col = 1'b0;
      e_rej = !c0 || !c1;
      ref_mem[DEPTH - left] = CV;
      left--;
    end else begin
      e_rej = 1'b0;
      e_v0  = !c0 && w0;
      e_v1  = !c1;
      e_col = !c0 && !w0 && !c1 && (a0 == a1) && (m != '0);
      if (e_v0) e_d0 = ref_mem[a0];
      if (e_v1) begin e_d1n = ref_mem[a1]; e_d1b = ref_mem[a1]; end
      if (!c0 && !w0)
        for (int i = 0; i < NM; i++)
          if (m[i]) ref_mem[a0][i*8 +: 8] = d0[i*8 +: 8];
      if (e_col) e_d1b = ref_mem[a1];
    end
    @(posedge clk); #1;
    check("dout0",      bi.dout0,       e_d0);
    check("dout0_v",    bi.dout0_valid, e_v0);
    check("dout1_byp",  bi.dout1,       e_d1b);
    check("dout1_nob",  bo.dout1,       e_d1n);
    check("dout1_v",    bi.dout1_valid, e_v1);
    check("busy",       bi.busy,        left > 0);
    check("reject",     bi.reject,      e_rej);
    check("collision",  bi.collision,   e_col);
    check("coll_nob",   bo.collision,   e_col);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  initial begin
    int n;
    // Reset and first sweep length
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bi.busy) n++;
      idle();
    end
    check("sweep_len", n, 16);

    // Port 1 reads of first and last word
    step(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b0, 4'd0);
    check("clr_a0", bi.dout1, CV);
    check("clr_a0_v", bi.dout1_valid, 1'b1);
    step(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b0, 4'd15);
    check("clr_a15", bi.dout1, CV);
    idle();
    check("v1_drop", bi.dout1_valid, 1'b0);

    // Masked write then read
    step(1'b0, 1'b0, 1'b0, 4'b0101, 4'd3, 32'h11223344, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0, 4'd3, '0, 1'b1, '0);
    check("mask_rd", bi.dout0, 32'hA522A544);
    check("mask_rd_v", bi.dout0_valid, 1'b1);

    // Same-address write/read collision
    step(1'b0, 1'b0, 1'b0, 4'b1111, 4'd7, 32'hDEADBEEF, 1'b0, 4'd7);
    check("col_pulse", bi.collision, 1'b1);
    check("col_byp", bi.dout1, 32'hDEADBEEF);
    check("col_nob", bo.dout1, CV);
    idle();
    check("col_drop", bi.collision, 1'b0);

    // Zero-mask write: no collision, no change
    step(1'b0, 1'b0, 1'b0, 4'b0000, 4'd5, 32'h12345678, 1'b0, 4'd5);
    check("zmask_nocol", bi.collision, 1'b0);
    check("zmask_d1", bi.dout1, CV);

    // Back-to-back reads
    step(1'b0, 1'b0, 1'b1, '0, 4'd1, '0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0, 4'd2, '0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0, 4'd3, '0, 1'b1, '0);
    check("b2b_v3", bi.dout0_valid, 1'b1);
    idle();
    check("b2b_hold", bi.dout0, 32'hA522A544);
    check("b2b_vdrop", bi.dout0_valid, 1'b0);

    // Reject during sweep, then reset mid-sweep
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    idle(); idle();
    step(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b0, 4'd2);
    check("rej_pulse", bi.reject, 1'b1);
    check("rej_nov", bi.dout1_valid, 1'b0);
    check("rej_d1", bi.dout1, 32'h0);
    for (int i = 0; i < 6; i++) idle();
    step(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, '0);
    check("midrst_busy", bi.busy, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bi.busy) n++;
      idle();
    end
    check("resweep_len", n, 16);
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 1'b0, 1'b1, '0, AW'(a), '0, 1'b1, '0);
      check("resweep_word", bi.dout0, CV);
    end

    // Randomised traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom), 1'($urandom), NM'($urandom),
           AW'($urandom), $urandom, 1'($urandom), AW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_1rw1r_wmask_clr.md
Name: sram_1rw1r_wmask_clr

Overview:
- Parametrised successor of the 1rw1r OpenRAM SRAM model: one read/write port (port 0) and one read-only port (port 1), both on a single clock.
- Adds generic width, depth and write-mask lane size.
- Adds registered read outputs with valid strobes and same-address read-during-write forwarding.
- Adds a reset-triggered memory-clear sequencer with busy/reject signalling. Used as the behavioural and synthesizable RAM for sky130 macro wrappers and for controller testbenches.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 8, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_LANE, 8, bits per write-mask lane; DATA_WIDTH must be an exact multiple.
- NUM_WMASKS, DATA_WIDTH/WMASK_LANE, number of mask bits (derived).
- BYPASS, 1, 1 = port 1 returns newly written data on a same-address collision; 0 = returns old data.
- CLEAR_ON_RESET, 1, 1 = sweep every word to CLEAR_VALUE after reset.
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill pattern.

Ports:
- clk0  in  1  single clock for both ports; all logic on its posedge.
- rst0  in  1  synchronous reset, active-high.
- csb0  in  1  port 0 select, active-low.
- web0  in  1  port 0 write enable, active-low (1 = read).
- wmask0  in  NUM_WMASKS  per-lane write enable, 1 = write lane.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_valid  out  1  one-cycle strobe qualifying dout0.
- csb1  in  1  port 1 select, active-low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_valid  out  1  one-cycle strobe qualifying dout1.
- busy  out  1  clear sweep in progress; commands ignored.
- reject  out  1  one-cycle pulse: a command (csb0=0 or csb1=0) arrived while busy.
- collision  out  1  one-cycle pulse: port 0 write and port 1 read to the same address on the same edge.

Behaviour:
- Reset (rst0=1 at an edge):
  - dout0=0, dout1=0; dout0_valid, dout1_valid, reject and collision = 0.
  - Clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET else IDLE; busy=1 if CLEAR_ON_RESET else 0.
  - Memory array is not reset directly.
- FSM:
  - CLEAR: each edge writes CLEAR_VALUE to mem[counter], then counter+1. When the edge writes counter==RAM_DEPTH-1, go to IDLE and set busy=0 (registered). After rst0 falls the sweep takes exactly RAM_DEPTH edges.
  - IDLE: normal operation; no other transitions.
  - rst0 mid-sweep restarts the sweep at counter 0.
- While busy:
  - csb0 and csb1 are ignored: no write, no valid strobe.
  - reject=1 in the following cycle if either csb is low.
- Port 0 write (csb0=0, web0=0 at edge N): lane i of mem[addr0] is replaced by din0 lane i for each wmask0[i]=1. Other lanes are unchanged. dout0 holds its value; no valid.
- Port 0 read (csb0=0, web0=1 at edge N): dout0 = mem[addr0] and dout0_valid=1 after edge N, i.e. latency 1. dout0_valid drops after edge N+1 unless another read occurs.
- Port 1 read (csb1=0 at edge N): same as a port 0 read, on dout1/dout1_valid.
- dout0/dout1 hold their last value when not reading; they never go to X.
- Collision (port 0 write, port 1 read, addr0==addr1, same edge):
  - collision=1 for one cycle.
  - BYPASS=1: dout1 takes masked lanes from din0 and unmasked lanes from the old word.
  - BYPASS=0: dout1 = old word.
  - The write always completes.
- Port 0 read and port 1 read to the same address: both return the same word; no collision.
- wmask0=0 write: no memory change and no collision pulse.
- Address wrap: no wrap; addresses are full-range, so RAM_DEPTH-1 is the last word.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DATA_WIDTH=32, ADDR_WIDTH=4, CLEAR_VALUE=32'hA5A5A5A5 -> busy high for exactly 16 cycles after rst0 falls. Then port 1 reads of addr 0 and 15 return 32'hA5A5A5A5 with dout1_valid one cycle after each command.
- After clear, write addr 3 din0=32'h11223344 wmask0=4'b0101 -> port 0 read of addr 3 returns 32'hA522A544, dout0_valid one cycle later.
- Same edge: port 0 writes addr 7 with 32'hDEADBEEF and wmask0=4'b1111; port 1 reads addr 7 -> collision=1. dout1=32'hDEADBEEF when BYPASS=1, 32'hA5A5A5A5 when BYPASS=0.
- Assert csb1=0 during the sweep -> reject=1 next cycle, no dout1_valid, dout1 unchanged at 0.
- Assert rst0 for one cycle at sweep cycle 9 -> busy stays high; sweep restarts and ends 16 cycles after rst0 falls. All words read back as CLEAR_VALUE.
- Back-to-back port 0 reads of addr 1, 2, 3 on consecutive edges -> dout0_valid high for 3 consecutive cycles with the matching data; dout0 holds the addr 3 data afterwards.
